// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard front end: filters the raw PS/2 lines, assembles 11-bit frames, decodes
// set-2 scancodes into lexer char codes and presents each code for one tokenize cycle.
`timescale 1ns/1ps
module ps2_key_encoder #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk_25mhz,
    input  logic       reset,
    input  logic       clk_io,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code_out,
    output logic       frame_err,
    output logic       overrun,
    output logic       shift_held
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic {S_IDLE, S_RECV} state_t;

    state_t        state_q, state_d;
    logic [1:0]    ps2c_sync_q, ps2c_sync_d, ps2d_sync_q, ps2d_sync_d;
    logic          filt_clk_q, filt_clk_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [10:0]   shreg_q, shreg_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          frame_err_q, frame_err_d;
    logic          byte_vld_q, byte_vld_d;
    logic [7:0]    byte_q, byte_d;
    logic          ext_q, ext_d, brk_q, brk_d;
    logic          shl_q, shl_d, shr_q, shr_d;
    logic          pend_vld_q, pend_vld_d;
    logic [7:0]    pend_q, pend_d;
    logic          overrun_q, overrun_d;
    logic          fall, present;
    logic [10:0]   shifted;
    logic [8:0]    dec;

    function automatic logic frame_ok(input logic [10:0] f);
        return (f[0] == 1'b0) && (f[10] == 1'b1) && (^f[9:1] == 1'b1);
    endfunction

    // Returns {valid, code}; break codes and unmapped keys never reach a valid result.
    function automatic logic [8:0] decode(input logic [7:0] sc, input logic ext, input logic shift);
        logic [8:0] r;
        logic [7:0] base;
        r    = 9'd0;
        base = 8'd0;
        if (ext) begin
            case (sc)
                8'h75:   r = {1'b1, 8'd67};
                8'h72:   r = {1'b1, 8'd68};
                default: r = 9'd0;
            endcase
        end else begin
            case (sc)
                8'h1C: base = 8'd1;   8'h32: base = 8'd2;   8'h21: base = 8'd3;
                8'h23: base = 8'd4;   8'h24: base = 8'd5;   8'h2B: base = 8'd6;
                8'h34: base = 8'd7;   8'h33: base = 8'd8;   8'h43: base = 8'd9;
                8'h3B: base = 8'd10;  8'h42: base = 8'd11;  8'h4B: base = 8'd12;
                8'h3A: base = 8'd13;  8'h31: base = 8'd14;  8'h44: base = 8'd15;
                8'h4D: base = 8'd16;  8'h15: base = 8'd17;  8'h2D: base = 8'd18;
                8'h1B: base = 8'd19;  8'h2C: base = 8'd20;  8'h3C: base = 8'd21;
                8'h2A: base = 8'd22;  8'h1D: base = 8'd23;  8'h22: base = 8'd24;
                8'h35: base = 8'd25;  8'h1A: base = 8'd26;
                default: base = 8'd0;
            endcase
            if (base != 8'd0) begin
                r = {1'b1, shift ? base + 8'd26 : base};
            end else begin
                case (sc)
                    8'h25:   if (shift)  r = {1'b1, 8'd53};
                    8'h46:   if (shift)  r = {1'b1, 8'd54};
                    8'h45:   if (shift)  r = {1'b1, 8'd55};
                    8'h55:   if (!shift) r = {1'b1, 8'd56};
                    8'h5D:   r = {1'b1, 8'd58};
                    8'h29:   r = {1'b1, 8'd59};
                    8'h49:   r = {1'b1, 8'd60};
                    8'h5A:   r = {1'b1, 8'd61};
                    8'h66:   r = {1'b1, 8'd65};
                    default: r = 9'd0;
                endcase
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ps2c_sync_q <= 2'b11;
            ps2d_sync_q <= 2'b11;
            filt_clk_q  <= 1'b1;
            filt_cnt_q  <= '0;
            bit_cnt_q   <= 4'd0;
            tmo_cnt_q   <= '0;
            frame_err_q <= 1'b0;
            byte_vld_q  <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            shl_q       <= 1'b0;
            shr_q       <= 1'b0;
            pend_vld_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ps2c_sync_q <= ps2c_sync_d;
            ps2d_sync_q <= ps2d_sync_d;
            filt_clk_q  <= filt_clk_d;
            filt_cnt_q  <= filt_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            frame_err_q <= frame_err_d;
            byte_vld_q  <= byte_vld_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            shl_q       <= shl_d;
            shr_q       <= shr_d;
            pend_vld_q  <= pend_vld_d;
            overrun_q   <= overrun_d;
        end
        shreg_q <= shreg_d;
        byte_q  <= byte_d;
        pend_q  <= pend_d;
    end

    always_comb begin
        state_d     = state_q;
        ps2c_sync_d = {ps2c_sync_q[0], ps2_clk};
        ps2d_sync_d = {ps2d_sync_q[0], ps2_data};
        filt_clk_d  = filt_clk_q;
        filt_cnt_d  = filt_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        tmo_cnt_d   = tmo_cnt_q;
        frame_err_d = 1'b0;
        byte_vld_d  = 1'b0;
        byte_d      = byte_q;
        ext_d       = ext_q;
        brk_d       = brk_q;
        shl_d       = shl_q;
        shr_d       = shr_q;
        pend_vld_d  = pend_vld_q;
        pend_d      = pend_q;
        overrun_d   = 1'b0;
        fall        = 1'b0;
        dec         = 9'd0;
        shifted     = {ps2d_sync_q[1], shreg_q[10:1]};

        // A new clock level is accepted only after FILTER_LEN consecutive differing samples.
        if (ps2c_sync_q[1] == filt_clk_q) begin
            filt_cnt_d = '0;
        end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
            filt_clk_d = ps2c_sync_q[1];
            filt_cnt_d = '0;
            fall       = filt_clk_q;
        end else begin
            filt_cnt_d = filt_cnt_q + FW'(1);
        end

        case (state_q)
            S_IDLE: begin
                tmo_cnt_d = '0;
                if (fall) begin
                    shreg_d   = shifted;
                    bit_cnt_d = 4'd1;
                    state_d   = S_RECV;
                end
            end
            default: begin
                if (fall) begin
                    shreg_d   = shifted;
                    tmo_cnt_d = '0;
                    if (bit_cnt_q == 4'd10) begin
                        state_d   = S_IDLE;
                        bit_cnt_d = 4'd0;
                        if (frame_ok(shifted)) begin
                            byte_vld_d = 1'b1;
                            byte_d     = shifted[8:1];
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (tmo_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_d     = S_IDLE;
                    bit_cnt_d   = 4'd0;
                    tmo_cnt_d   = '0;
                    frame_err_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
        endcase

        if (byte_vld_q) begin
            if (byte_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (byte_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (!ext_q && byte_q == 8'h12)      shl_d = !brk_q;
                else if (!ext_q && byte_q == 8'h59) shr_d = !brk_q;
                else if (!brk_q)                    dec   = decode(byte_q, ext_q, shl_q | shr_q);
            end
        end

        // The presenting slot frees this cycle, so a same-cycle decode loads rather than overruns.
        if (present) pend_vld_d = 1'b0;
        if (dec[8]) begin
            if (pend_vld_q && !present) begin
                overrun_d = 1'b1;
            end else begin
                pend_vld_d = 1'b1;
                pend_d     = dec[7:0];
            end
        end
    end

    always_comb begin
        present    = pend_vld_q & ~clk_io;
        code_out   = present ? pend_q : 8'h00;
        frame_err  = frame_err_q;
        overrun    = overrun_q;
        shift_held = shl_q | shr_q;
    end
endmodule

// File: tb/tb_ps2_key_encoder.sv
// Bench for ps2_key_encoder: table of scancode sequences, hand-written corner cases and a
// randomized key stream checked against a behavioural keyboard model.
`timescale 1ns/1ps
module tb_ps2_key_encoder;
    localparam int HALF = 14;
    localparam int TMO  = 2000;

    logic       clk = 1'b0;
    logic       reset, clk_io, ps2_clk, ps2_data;
    logic [7:0] code_out;
    logic       frame_err, overrun, shift_held;

    int n_cmp = 0, n_bad = 0;
    int ferr_cnt = 0, ovr_cnt = 0, io_viol = 0;
    bit rand_io = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    typedef struct {
        logic [23:0] seq;
        int          n;
        int          code;
        int          sh;
    } vec_t;
    vec_t tbl[29];

    logic [7:0] letters[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] extras[13]  = '{8'h12, 8'h59, 8'h25, 8'h46, 8'h45, 8'h55, 8'h5D, 8'h29, 8'h49,
                                8'h5A, 8'h66, 8'h75, 8'h72};

    always #20 clk = ~clk;

    ps2_key_encoder #(.FILTER_LEN(8), .TIMEOUT_CYC(TMO)) dut (
        .clk_25mhz (clk),
        .reset     (reset),
        .clk_io    (clk_io),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .code_out  (code_out),
        .frame_err (frame_err),
        .overrun   (overrun),
        .shift_held(shift_held)
    );

    always @(negedge clk) begin
        if (code_out != 8'd0) begin
            got_q.push_back(code_out);
            if (clk_io) io_viol++;
        end
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
    end

    initial begin
        #3_600_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_io) clk_io = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input int nbits, input bit flip);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            wait_cyc(HALF);
            ps2_clk = 1'b0;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        wait_cyc(HALF);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 11, 1'b0);
    endtask

    // Key code a keyboard user expects for a make event; 0 when nothing should be typed.
    function automatic int model_code(input logic [7:0] k, input bit ext, input bit sh);
        if (ext) return (k == 8'h75) ? 67 : ((k == 8'h72) ? 68 : 0);
        for (int i = 0; i < 26; i++)
            if (letters[i] == k) return i + 1 + (sh ? 26 : 0);
        case (k)
            8'h25: return sh ? 53 : 0;
            8'h46: return sh ? 54 : 0;
            8'h45: return sh ? 55 : 0;
            8'h55: return sh ? 0 : 56;
            8'h5D: return 58;
            8'h29: return 59;
            8'h49: return 60;
            8'h5A: return 61;
            8'h66: return 65;
            default: return 0;
        endcase
    endfunction

    initial begin
        int f0, o0, c;
        bit sl, sr, ext, brk;
        logic [7:0] key;

        tbl = '{
            '{24'h1C0000, 1, 1, 0},  '{24'h120000, 1, 0, 1},  '{24'h1C0000, 1, 27, 1},
            '{24'hF01C00, 2, 0, 1},  '{24'hF01200, 2, 0, 0},  '{24'h1C0000, 1, 1, 0},
            '{24'hE07500, 2, 67, 0}, '{24'hE0F075, 3, 0, 0},  '{24'h5A0000, 1, 61, 0},
            '{24'h290000, 1, 59, 0}, '{24'h5D0000, 1, 58, 0}, '{24'h122500, 2, 53, 1},
            '{24'hF01200, 2, 0, 0},  '{24'h594600, 2, 54, 1}, '{24'h594500, 2, 55, 1},
            '{24'h550000, 1, 0, 1},  '{24'hF05900, 2, 0, 0},  '{24'h450000, 1, 0, 0},
            '{24'h460000, 1, 0, 0},  '{24'h550000, 1, 56, 0}, '{24'h490000, 1, 60, 0},
            '{24'h660000, 1, 65, 0}, '{24'hE07200, 2, 68, 0}, '{24'hE01C00, 2, 0, 0},
            '{24'h1A0000, 1, 26, 0}, '{24'h4B0000, 1, 12, 0}, '{24'hF04B00, 2, 0, 0},
            '{24'h123200, 2, 28, 1}, '{24'hF01200, 2, 0, 0}
        };

        reset = 1'b1; clk_io = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
        wait_cyc(4);
        check("reset_code_out", int'(code_out), 0);
        check("reset_frame_err", int'(frame_err), 0);
        check("reset_overrun", int'(overrun), 0);
        check("reset_shift_held", int'(shift_held), 0);
        reset = 1'b0;
        wait_cyc(2);

        for (int i = 0; i < 29; i++) begin
            got_q.delete();
            for (int j = 0; j < tbl[i].n; j++) send_byte(tbl[i].seq[23 - 8*j -: 8]);
            wait_cyc(5);
            check($sformatf("vec%0d_count", i), got_q.size(), (tbl[i].code != 0) ? 1 : 0);
            if (tbl[i].code != 0 && got_q.size() > 0)
                check($sformatf("vec%0d_code", i), int'(got_q[0]), tbl[i].code);
            check($sformatf("vec%0d_shift", i), int'(shift_held), tbl[i].sh);
        end

        f0 = ferr_cnt; got_q.delete();
        send_frame(8'h1C, 11, 1'b1);
        wait_cyc(5);
        check("parity_err_pulse", ferr_cnt - f0, 1);
        check("parity_err_nocode", got_q.size(), 0);

        clk_io = 1'b1; got_q.delete();
        send_byte(8'h4B);
        wait_cyc(10);
        check("held_io_nocode", got_q.size(), 0);
        clk_io = 1'b0;
        wait_cyc(1);
        clk_io = 1'b1;
        wait_cyc(3);
        check("held_io_count", got_q.size(), 1);
        if (got_q.size() > 0) check("held_io_code", int'(got_q[0]), 12);

        o0 = ovr_cnt; got_q.delete();
        send_byte(8'h1C);
        send_byte(8'h32);
        wait_cyc(5);
        check("overrun_pulse", ovr_cnt - o0, 1);
        clk_io = 1'b0;
        wait_cyc(5);
        check("overrun_count", got_q.size(), 1);
        if (got_q.size() > 0) check("overrun_kept", int'(got_q[0]), 1);

        send_byte(8'h12);
        wait_cyc(3);
        check("pre_reset_shift", int'(shift_held), 1);
        send_frame(8'h1C, 5, 1'b0);
        reset = 1'b1;
        wait_cyc(2);
        reset = 1'b0;
        wait_cyc(2);
        check("midreset_shift", int'(shift_held), 0);
        f0 = ferr_cnt; got_q.delete();
        send_byte(8'h1C);
        wait_cyc(5);
        check("midreset_count", got_q.size(), 1);
        if (got_q.size() > 0) check("midreset_code", int'(got_q[0]), 1);
        check("midreset_noerr", ferr_cnt - f0, 0);

        f0 = ferr_cnt;
        send_frame(8'h1C, 5, 1'b0);
        wait_cyc(TMO + 100);
        check("timeout_pulse", ferr_cnt - f0, 1);
        got_q.delete();
        send_byte(8'h1C);
        wait_cyc(5);
        check("timeout_recover_count", got_q.size(), 1);
        if (got_q.size() > 0) check("timeout_recover_code", int'(got_q[0]), 1);

        sl = 1'b0; sr = 1'b0;
        o0 = ovr_cnt; io_viol = 0;
        got_q.delete(); exp_q.delete();
        rand_io = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 9) == 0) key = 8'($urandom_range(1, 127));
            else begin
                c = $urandom_range(0, 38);
                key = (c < 26) ? letters[c] : extras[c - 26];
            end
            ext = ($urandom_range(0, 5) == 0);
            brk = ($urandom_range(0, 2) == 0);
            if (ext) send_byte(8'hE0);
            if (brk) send_byte(8'hF0);
            send_byte(key);
            if (!ext && key == 8'h12)      sl = !brk;
            else if (!ext && key == 8'h59) sr = !brk;
            else if (!brk) begin
                c = model_code(key, ext, sl | sr);
                if (c != 0) exp_q.push_back(8'(c));
            end
        end
        rand_io = 1'b0;
        clk_io = 1'b0;
        wait_cyc(10);
        check("rand_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("rand_code%0d", i), int'(got_q[i]), int'(exp_q[i]));
        check("rand_shift", int'(shift_held), int'(sl | sr));
        check("rand_no_overrun", ovr_cnt - o0, 0);
        check("rand_io_phase", io_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
